// File: rtl/sudoku_puzzle_feeder_if.sv
// rtl/sudoku_puzzle_feeder_if.sv - row stream, core puzzle handoff and result stream signals
interface sudoku_puzzle_feeder_if;
  logic         in_valid;
  logic         in_ready;
  logic [35:0]  in_row;
  logic [323:0] puzzle_in;
  logic         puzzle_avail;
  logic         read_puzzle;
  logic         done_puzzle;
  logic [323:0] puzzle_out;
  logic         out_valid;
  logic         out_ready;
  logic [35:0]  out_row;
  logic [15:0]  puzzles_in_cnt;
  logic [15:0]  puzzles_out_cnt;

  modport slave (
    input  in_valid, in_row, read_puzzle, done_puzzle, puzzle_out, out_ready,
    output in_ready, puzzle_in, puzzle_avail, out_valid, out_row,
           puzzles_in_cnt, puzzles_out_cnt
  );

  modport master (
    output in_valid, in_row, read_puzzle, done_puzzle, puzzle_out, out_ready,
    input  in_ready, puzzle_in, puzzle_avail, out_valid, out_row,
           puzzles_in_cnt, puzzles_out_cnt
  );
endinterface

// File: rtl/sudoku_puzzle_feeder.sv
// rtl/sudoku_puzzle_feeder.sv - assembles 9-row puzzles for the solver core and streams results back out
module sudoku_puzzle_feeder (
  input  logic                  clk,
  input  logic                  rst,
  sudoku_puzzle_feeder_if.slave bus
);

  logic [323:0] asm_data;
  logic [323:0] head_data;
  logic [323:0] res_data;
  logic [3:0]   row_cnt;
  logic [3:0]   res_idx;
  logic         asm_full;
  logic         head_valid;
  logic         res_valid;
  logic [15:0]  in_cnt;
  logic [15:0]  out_cnt;
  logic [35:0]  row_sel;

  logic accept;
  logic pop;
  logic load;
  logic capture;
  logic out_fire;

  assign accept   = bus.in_valid && !asm_full;
  assign pop      = bus.read_puzzle && head_valid;
  assign load     = asm_full && (!head_valid || pop);
  assign capture  = bus.done_puzzle && !res_valid;
  assign out_fire = res_valid && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_data <= '0;
      row_cnt  <= '0;
      asm_full <= 1'b0;
    end else if (accept) begin
      for (int r = 0; r < 9; r++) begin
        if (row_cnt == 4'(r)) asm_data[323-36*r -: 36] <= bus.in_row;
      end
      if (row_cnt == 4'd8) begin
        row_cnt  <= '0;
        asm_full <= 1'b1;
      end else begin
        row_cnt <= row_cnt + 4'd1;
      end
    end else if (load) begin
      asm_full <= 1'b0;
    end
  end

  // A pop with the assembly register full hands over in the same cycle, so head_valid stays high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_data  <= '0;
      head_valid <= 1'b0;
      in_cnt     <= '0;
    end else begin
      if (load) begin
        head_data  <= asm_data;
        head_valid <= 1'b1;
      end else if (pop) begin
        head_valid <= 1'b0;
      end
      if (pop) in_cnt <= in_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_data  <= '0;
      res_valid <= 1'b0;
      res_idx   <= '0;
      out_cnt   <= '0;
    end else if (capture) begin
      res_data  <= bus.puzzle_out;
      res_valid <= 1'b1;
      res_idx   <= '0;
    end else if (out_fire) begin
      if (res_idx == 4'd8) begin
        res_valid <= 1'b0;
        out_cnt   <= out_cnt + 16'd1;
      end else begin
        res_idx <= res_idx + 4'd1;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && bus.done_puzzle && res_valid)
      $error("sudoku_puzzle_feeder: done_puzzle dropped, result slot still busy");
  end
`endif

  always_comb begin
    row_sel = '0;
    for (int r = 0; r < 9; r++) begin
      if (res_idx == 4'(r)) row_sel = res_data[323-36*r -: 36];
    end
  end

  assign bus.in_ready        = !asm_full;
  assign bus.puzzle_in       = head_valid ? head_data : '0;
  assign bus.puzzle_avail    = head_valid && !res_valid;
  assign bus.out_valid       = res_valid;
  assign bus.out_row         = res_valid ? row_sel : '0;
  assign bus.puzzles_in_cnt  = in_cnt;
  assign bus.puzzles_out_cnt = out_cnt;

endmodule
